// File: rtl/dw_stack_lvl.sv
// LIFO stack with level flags, word count and replace-top on simultaneous push/pop.
// Register storage; top-of-stack is read combinationally from the registered count.
module dw_stack_lvl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AE_LEVEL = 1,
    parameter int AF_LEVEL = 1,
    parameter int ERR_MODE = 0,
    parameter int RST_MODE = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req_n,
    input  logic             pop_req_n,
    input  logic [WIDTH-1:0] data_in,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             full,
    output logic             error,
    output logic [CW-1:0]    word_count,
    output logic [WIDTH-1:0] data_out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             push, pop, bad;

    assign push = ~push_req_n;
    assign pop  = ~pop_req_n;

    always_comb begin
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = AW'(cnt_q);
        bad     = 1'b0;
        if (push && pop) begin
            wr_en = 1'b1;
            if (cnt_q != '0) begin
                wr_addr = AW'(cnt_q - CW'(1));
            end else begin
                // Nothing to replace: the push still lands, the pop underflows.
                cnt_d = CW'(1);
                bad   = 1'b1;
            end
        end else if (push) begin
            if (cnt_q != CW'(DEPTH)) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + CW'(1);
            end else begin
                bad = 1'b1;
            end
        end else if (pop) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                bad = 1'b1;
            end
        end
        err_d = (ERR_MODE == 0) ? (err_q | bad) : bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    if (RST_MODE == 0) begin
                        mem_q[gi] <= '0;
                    end
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    mem_q[gi] <= data_in;
                end
            end
        end
    endgenerate

    assign rd_addr      = AW'(cnt_q - CW'(1));
    assign data_out     = (cnt_q == '0) ? '0 : mem_q[rd_addr];
    assign word_count   = cnt_q;
    assign error        = err_q;
    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CW'(DEPTH));
    assign almost_empty = (cnt_q <= CW'(AE_LEVEL));
    assign half_full    = (cnt_q >= CW'((DEPTH + 1) / 2));
    assign almost_full  = (cnt_q >= CW'(DEPTH - AF_LEVEL));

endmodule

// File: tb/tb_dw_stack_lvl.sv
// Bench for dw_stack_lvl: sticky-error/clear-storage and pulse-error/keep-storage
// instances share stimulus and are compared each cycle against a queue model.
module tb_dw_stack_lvl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_req_n = 1'b1;
    logic       pop_req_n = 1'b1;
    logic [7:0] data_in = '0;

    logic       a_e, a_ae, a_hf, a_af, a_f, a_err;
    logic [3:0] a_wc;
    logic [7:0] a_d;
    logic       b_e, b_ae, b_hf, b_af, b_f, b_err;
    logic [3:0] b_wc;
    logic [7:0] b_d;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    logic [7:0] stk[$];
    bit err_s = 1'b0;
    bit err_p = 1'b0;

    dw_stack_lvl #(.WIDTH(8), .DEPTH(DEPTH), .AE_LEVEL(1), .AF_LEVEL(1),
                   .ERR_MODE(0), .RST_MODE(0)) u_a (
        .clk(clk), .rst(rst), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
        .data_in(data_in), .empty(a_e), .almost_empty(a_ae), .half_full(a_hf),
        .almost_full(a_af), .full(a_f), .error(a_err), .word_count(a_wc),
        .data_out(a_d));

    dw_stack_lvl #(.WIDTH(8), .DEPTH(DEPTH), .AE_LEVEL(1), .AF_LEVEL(1),
                   .ERR_MODE(1), .RST_MODE(1)) u_b (
        .clk(clk), .rst(rst), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
        .data_in(data_in), .empty(b_e), .almost_empty(b_ae), .half_full(b_hf),
        .almost_full(b_af), .full(b_f), .error(b_err), .word_count(b_wc),
        .data_out(b_d));

    always #5 clk = ~clk;

    task automatic cmp(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(bit r, bit pu, bit po, logic [7:0] d);
        bit bad;
        bad = 1'b0;
        if (r) begin
            stk.delete();
            err_s = 1'b0;
            err_p = 1'b0;
        end else begin
            if (pu && po) begin
                if (stk.size() > 0) stk[stk.size()-1] = d;
                else begin stk.push_back(d); bad = 1'b1; end
            end else if (pu) begin
                if (stk.size() < DEPTH) stk.push_back(d);
                else bad = 1'b1;
            end else if (po) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else bad = 1'b1;
            end
            err_s = err_s | bad;
            err_p = bad;
        end
    endtask

    task automatic step(bit r, bit pu, bit po, logic [7:0] d);
        rst        = r;
        push_req_n = ~pu;
        pop_req_n  = ~po;
        data_in    = d;
        @(posedge clk);
        model_edge(r, pu, po, d);
        #1;
    endtask

    task automatic chk_inst(string tag, logic e, logic ae, logic hf, logic af,
                            logic f, logic er, logic [3:0] wc, logic [7:0] dout,
                            bit pulse_mode);
        int n;
        n = stk.size();
        cmp({tag, ".word_count"},   int'(wc),  n);
        cmp({tag, ".empty"},        int'(e),   int'(n == 0));
        cmp({tag, ".almost_empty"}, int'(ae),  int'(n <= 1));
        cmp({tag, ".half_full"},    int'(hf),  int'(n >= (DEPTH + 1) / 2));
        cmp({tag, ".almost_full"},  int'(af),  int'(n >= DEPTH - 1));
        cmp({tag, ".full"},         int'(f),   int'(n == DEPTH));
        cmp({tag, ".error"},        int'(er),  int'(pulse_mode ? err_p : err_s));
        cmp({tag, ".data_out"},     int'(dout), (n > 0) ? int'(stk[n-1]) : 0);
    endtask

    // Cycle-by-cycle comparison, sampled mid-period.
    always @(negedge clk) begin
        if (check_en) begin
            chk_inst("A", a_e, a_ae, a_hf, a_af, a_f, a_err, a_wc, a_d, 1'b0);
            chk_inst("B", b_e, b_ae, b_hf, b_af, b_f, b_err, b_wc, b_d, 1'b1);
        end
    end

    initial begin
        logic [7:0] v;
        int pp;

        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        check_en = 1'b1;
        cmp("rst.word_count", int'(a_wc), 0);
        cmp("rst.empty", int'(a_e), 1);
        cmp("rst.almost_empty", int'(a_ae), 1);
        cmp("rst.data_out", int'(a_d), 0);
        cmp("rst.error", int'(b_err), 0);

        // Fill to full with 0x11..0x88
        for (int k = 1; k <= 8; k++) begin
            v = 8'(k * 8'h11);
            step(0, 1, 0, v);
            if (k == 6) cmp("fill6.almost_full", int'(a_af), 0);
            if (k == 7) cmp("fill7.almost_full", int'(a_af), 1);
            if (k == 7) cmp("fill7.full", int'(a_f), 0);
        end
        cmp("fill.full", int'(a_f), 1);
        cmp("fill.word_count", int'(a_wc), 8);
        cmp("fill.data_out", int'(a_d), 'h88);

        // Overflow
        step(0, 1, 0, 8'h99);
        cmp("ovf.errA", int'(a_err), 1);
        cmp("ovf.errB", int'(b_err), 1);
        cmp("ovf.word_count", int'(a_wc), 8);
        cmp("ovf.data_out", int'(a_d), 'h88);
        step(0, 0, 0, 8'h00);
        cmp("ovf_hold.errA", int'(a_err), 1);
        cmp("ovf_hold.errB", int'(b_err), 0);

        // Replace top while full
        step(0, 1, 1, 8'hA5);
        cmp("rep.data_out", int'(a_d), 'hA5);
        cmp("rep.word_count", int'(a_wc), 8);
        cmp("rep.errB", int'(b_err), 0);

        // Drain
        for (int k = 7; k >= 0; k--) begin
            step(0, 0, 1, 8'h00);
            cmp("drain.data_out", int'(a_d), k * 'h11);
        end
        cmp("drain.empty", int'(a_e), 1);
        step(0, 0, 1, 8'h00);
        cmp("udf.errB", int'(b_err), 1);
        cmp("udf.word_count", int'(a_wc), 0);

        // Push+pop on empty
        step(1, 0, 0, 8'h00);
        step(0, 1, 1, 8'h3C);
        cmp("pp0.word_count", int'(a_wc), 1);
        cmp("pp0.data_out", int'(a_d), 'h3C);
        cmp("pp0.errA", int'(a_err), 1);
        cmp("pp0.errB", int'(b_err), 1);

        // Reset mid-sequence at word_count=5 with a push pending
        for (int k = 0; k < 4; k++) step(0, 1, 0, 8'(8'h40 + k));
        cmp("mid.word_count", int'(a_wc), 5);
        step(1, 1, 0, 8'hEE);
        cmp("midrst.word_count", int'(a_wc), 0);
        cmp("midrst.empty", int'(a_e), 1);
        cmp("midrst.error", int'(a_err), 0);
        cmp("midrst.data_out", int'(a_d), 0);

        // Randomized traffic with fill-biased and drain-biased phases
        for (int i = 0; i < 3000; i++) begin
            case ((i / 120) % 3)
                0: pp = 70;
                1: pp = 30;
                default: pp = 50;
            endcase
            step($urandom_range(0, 60) == 0,
                 $urandom_range(0, 99) < pp,
                 $urandom_range(0, 99) < (100 - pp),
                 8'($urandom));
        end

        step(0, 0, 0, 8'h00);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
